lms_ctr_oc_mem_loader: RTL and testbench

Avalon-MM master that fills the lms_ctr on-chip program/data memory from a byte stream (flash reader or FT601 control path) before the CPU is released. It packs incoming bytes little-endian into 32-bit words, writes them to consecutive word addresses with correct byte enables on a partial final word, and holds the CPU reset request while loading. Optionally, it re-reads the image and compares a checksum.

---
 rtl/lms_ctr_oc_mem_loader_pkg.sv | 40 ++++
 rtl/lms_ctr_oc_mem_loader_if.sv | 35 +++
 rtl/lms_ctr_oc_mem_byte_pack.sv | 59 +++++
 rtl/lms_ctr_oc_mem_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_lms_ctr_oc_mem_loader.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lms_ctr_oc_mem_loader_pkg.sv
// lms_ctr_oc_mem_loader_pkg
// Shared types and helpers for the lms_ctr on-chip memory loader.
//   state_t        : loader FSM states
//   BYTES_PER_WORD : bytes packed into one 32-bit memory word
//   lane_mask()    : byte enables of the final word from the image length mod 4
//   be_to_bits()   : expands a 4-bit byte enable into a 32-bit bit mask
package lms_ctr_oc_mem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    VERIFY_RD,
    VERIFY_WAIT,
    FINISH
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // A length that is a multiple of four leaves a full final word.
  function automatic logic [3:0] lane_mask(input logic [1:0] len_mod);
    logic [3:0] mask;
    case (len_mod)
      2'd1:    mask = 4'b0001;
      2'd2:    mask = 4'b0011;
      2'd3:    mask = 4'b0111;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] be_to_bits(input logic [3:0] be);
    logic [31:0] bits;
    for (int i = 0; i < 4; i++) begin
      bits[8*i +: 8] = {8{be[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/lms_ctr_oc_mem_loader_if.sv
// lms_ctr_oc_mem_loader_if
// Groups the byte stream and the Avalon-MM master signals of the loader.
//   st_data/st_valid/st_ready         : incoming byte stream
//   avm_address/write/read/writedata/
//   avm_byteenable                    : Avalon-MM requests issued by the loader
//   avm_waitrequest/readdata/
//   avm_readdatavalid                 : Avalon-MM responses from the interconnect
// Modport master is the loader's view, slave is the stream source plus memory.
interface lms_ctr_oc_mem_loader_if #(
  parameter int ADDR_W = 12
);

  logic [7:0]        st_data;
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic              avm_read;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    input  st_data, st_valid, avm_waitrequest, avm_readdata, avm_readdatavalid,
    output st_ready, avm_address, avm_write, avm_read, avm_writedata, avm_byteenable
  );

  modport slave (
    output st_data, st_valid, avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  st_ready, avm_address, avm_write, avm_read, avm_writedata, avm_byteenable
  );

endinterface

// File: rtl/lms_ctr_oc_mem_byte_pack.sv
// lms_ctr_oc_mem_byte_pack
// Packs stream bytes little-endian into a 32-bit word and tracks how many
// image bytes are still expected.
//   load/load_len : start of an image, loads the remaining-byte counter
//   accept/byte_in: one stream byte taken this cycle
//   clear_word    : current word has been written, start a fresh one
//   word/byteenable: word under construction and its filled lanes
//   bytes_left    : image bytes not yet accepted
//   flush         : the byte accepted this cycle completes the word
module lms_ctr_oc_mem_byte_pack
  import lms_ctr_oc_mem_loader_pkg::*;
#(
  parameter int LEN_W = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [LEN_W-1:0] load_len,
  input  logic             accept,
  input  logic [7:0]       byte_in,
  input  logic             clear_word,
  output logic [31:0]      word,
  output logic [3:0]       byteenable,
  output logic [LEN_W-1:0] bytes_left,
  output logic             flush
);

  logic [1:0] lane;

  // A word is complete when its top lane fills or the image runs out early.
  assign flush = accept &&
                 ((lane == 2'(BYTES_PER_WORD - 1)) || (bytes_left == LEN_W'(1)));

  // Lane pointer, packed word and byte counter; clearing the word also zeroes
  // the data so unused lanes of a partial final word never carry stale bytes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane       <= 2'd0;
      word       <= 32'd0;
      byteenable <= 4'd0;
      bytes_left <= '0;
    end else if (load) begin
      lane       <= 2'd0;
      word       <= 32'd0;
      byteenable <= 4'd0;
      bytes_left <= load_len;
    end else if (clear_word) begin
      lane       <= 2'd0;
      word       <= 32'd0;
      byteenable <= 4'd0;
    end else if (accept) begin
      word[{lane, 3'b000} +: 8] <= byte_in;
      byteenable[lane]          <= 1'b1;
      lane                      <= lane + 2'd1;
      bytes_left                <= bytes_left - LEN_W'(1);
    end
  end

endmodule

// File: rtl/lms_ctr_oc_mem_loader.sv
// lms_ctr_oc_mem_loader
// Avalon-MM master that copies a byte stream into the lms_ctr on-chip memory
// while holding the CPU in reset, then optionally re-reads and checks it.
//   clk, reset_n       : clock, asynchronous active-low reset
//   start              : one-cycle load request (ignored while busy / on done)
//   base_addr          : first word address
//   len_bytes          : image length in bytes
//   bus                : stream + Avalon-MM master (lms_ctr_oc_mem_loader_if.master)
//   cpu_reset_req/busy : high while a load is in progress
//   done               : one-cycle completion pulse
//   error              : sticky range/verify error, cleared by the next start
//   checksum           : mod-2^32 sum of the written words (disabled lanes as 0)
// Optional feature macro: LMS_CTR_OC_MEM_LOADER_VERIFY_EN adds the read-back pass.
module lms_ctr_oc_mem_loader
  import lms_ctr_oc_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int LEN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [LEN_W-1:0]      len_bytes,
  lms_ctr_oc_mem_loader_if.master bus,
  output logic                  cpu_reset_req,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           checksum
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sum_q;
  logic              done_q;
  logic              error_q;

  logic              start_ok;
  logic              len_zero;
  logic              range_err;
  logic [31:0]       need_words;
  logic              write_ack;
  logic              last_word_written;
  logic              st_ready_c;
  logic              avm_write_c;

  logic [31:0]       pk_word;
  logic [3:0]        pk_be;
  logic [LEN_W-1:0]  pk_left;
  logic              pk_flush;

  // A start landing on the done cycle must not restart the loader.
  assign start_ok  = (state == IDLE) && start && !done_q;
  assign len_zero  = (len_bytes == '0);

  // The image must fit between base_addr and the top of memory; checking it
  // up front means the address counter can never wrap during a load.
  assign need_words = (32'(len_bytes) + 32'd3) >> 2;
  assign range_err  = !len_zero &&
                      ((32'(base_addr) >= 32'(DEPTH)) ||
                       (need_words > (32'(DEPTH) - 32'(base_addr))));

  assign write_ack         = (state == WRITE) && !bus.avm_waitrequest;
  assign last_word_written = (pk_left == '0);

  lms_ctr_oc_mem_byte_pack #(
    .LEN_W (LEN_W)
  ) u_pack (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (start_ok),
    .load_len   (len_bytes),
    .accept     (st_ready_c && bus.st_valid),
    .byte_in    (bus.st_data),
    .clear_word (write_ack),
    .word       (pk_word),
    .byteenable (pk_be),
    .bytes_left (pk_left),
    .flush      (pk_flush)
  );

`ifdef LMS_CTR_OC_MEM_LOADER_VERIFY_EN
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [31:0]       rd_sum_q;
  logic [LEN_W-1:0]  rd_left_q;
  logic              rd_last;
  logic [3:0]        rd_be;
  logic              avm_read_c;

  // Only the final word of a non-multiple-of-4 image has masked lanes.
  assign rd_last = (rd_left_q <= LEN_W'(BYTES_PER_WORD));
  assign rd_be   = rd_last ? lane_mask(len_q[1:0]) : 4'hF;

  // Read-back bookkeeping: the byte count is reloaded after the last write so
  // the read pass knows which word is the (possibly partial) final one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q    <= '0;
      len_q     <= '0;
      rd_sum_q  <= 32'd0;
      rd_left_q <= '0;
    end else if (start_ok) begin
      base_q    <= base_addr;
      len_q     <= len_bytes;
      rd_sum_q  <= 32'd0;
    end else if (write_ack && last_word_written) begin
      rd_left_q <= len_q;
    end else if ((state == VERIFY_WAIT) && bus.avm_readdatavalid) begin
      rd_sum_q  <= rd_sum_q + (bus.avm_readdata & be_to_bits(rd_be));
      rd_left_q <= rd_left_q - LEN_W'(BYTES_PER_WORD);
    end
  end

  assign bus.avm_read = avm_read_c;
`else
  logic unused_rd;
  assign unused_rd    = ^{bus.avm_readdata, bus.avm_readdatavalid};
  assign bus.avm_read = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and bus strobes. Requests are held in WRITE/VERIFY_RD until the
  // interconnect drops waitrequest, so address and data stay stable meanwhile.
  always_comb begin
    state_nxt   = state;
    st_ready_c  = 1'b0;
    avm_write_c = 1'b0;
`ifdef LMS_CTR_OC_MEM_LOADER_VERIFY_EN
    avm_read_c  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_ok) begin
          if (len_zero || range_err) state_nxt = FINISH;
          else                       state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        st_ready_c = 1'b1;
        if (pk_flush) state_nxt = WRITE;
      end
      WRITE: begin
        avm_write_c = 1'b1;
        if (!bus.avm_waitrequest) begin
          if (!last_word_written) begin
            state_nxt = COLLECT;
          end else begin
`ifdef LMS_CTR_OC_MEM_LOADER_VERIFY_EN
            state_nxt = VERIFY_RD;
`else
            state_nxt = FINISH;
`endif
          end
        end
      end
`ifdef LMS_CTR_OC_MEM_LOADER_VERIFY_EN
      VERIFY_RD: begin
        avm_read_c = 1'b1;
        if (!bus.avm_waitrequest) state_nxt = VERIFY_WAIT;
      end
      VERIFY_WAIT: begin
        if (bus.avm_readdatavalid) begin
          if (rd_last) state_nxt = FINISH;
          else         state_nxt = VERIFY_RD;
        end
      end
`endif
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Address, checksum, done pulse and sticky error. done is registered so it
  // appears together with the return to IDLE, which is when busy drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      sum_q   <= 32'd0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= (state == FINISH);
      if (start_ok) begin
        addr_q  <= base_addr;
        sum_q   <= 32'd0;
        error_q <= range_err;
      end else if (write_ack) begin
        sum_q <= sum_q + (pk_word & be_to_bits(pk_be));
`ifdef LMS_CTR_OC_MEM_LOADER_VERIFY_EN
        addr_q <= last_word_written ? base_q : addr_q + ADDR_W'(1);
`else
        addr_q <= addr_q + ADDR_W'(1);
`endif
      end
`ifdef LMS_CTR_OC_MEM_LOADER_VERIFY_EN
      else if ((state == VERIFY_WAIT) && bus.avm_readdatavalid) begin
        addr_q <= addr_q + ADDR_W'(1);
      end else if ((state == FINISH) && (rd_sum_q != sum_q)) begin
        error_q <= 1'b1;
      end
`endif
    end
  end

  assign bus.st_ready       = st_ready_c;
  assign bus.avm_write      = avm_write_c;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = pk_word;
  assign bus.avm_byteenable = pk_be;
  assign busy               = (state != IDLE);
  assign cpu_reset_req      = busy;
  assign done               = done_q;
  assign error              = error_q;
  assign checksum           = sum_q;

endmodule

// File: tb/tb_lms_ctr_oc_mem_loader.sv
// tb_lms_ctr_oc_mem_loader
// Self-checking bench for lms_ctr_oc_mem_loader: drives byte images into the
// loader, models the memory slave (waitrequest stalls, read-back with optional
// corruption) and compares writes, checksum, error and done timing against a
// reference computed from the image bytes.
// Honours LMS_CTR_OC_MEM_LOADER_VERIFY_EN when the design is built with it.
module tb_lms_ctr_oc_mem_loader;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;
  localparam int LEN_W  = 14;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  len_bytes = '0;
  logic              cpu_reset_req;
  logic              busy;
  logic              done;
  logic              error;
  logic [31:0]       checksum;

  lms_ctr_oc_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  lms_ctr_oc_mem_loader #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .base_addr     (base_addr),
    .len_bytes     (len_bytes),
    .bus           (bus),
    .cpu_reset_req (cpu_reset_req),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .checksum      (checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory slave state shared with the stimulus tasks.
  logic [31:0]       mem [0:DEPTH-1];
  int                stall_mode = 0;
  logic              corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [31:0]       wr_data_q [$];
  logic [3:0]        wr_be_q [$];
  int                read_seen = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_st_ready", 32'(bus.st_ready), 32'd0);
    checkOutput("rst_avm_write", 32'(bus.avm_write), 32'd0);
    checkOutput("rst_avm_read", 32'(bus.avm_read), 32'd0);
    checkOutput("rst_avm_address", 32'(bus.avm_address), 32'd0);
    checkOutput("rst_avm_writedata", bus.avm_writedata, 32'd0);
    checkOutput("rst_avm_byteenable", 32'(bus.avm_byteenable), 32'd0);
    checkOutput("rst_cpu_reset_req", 32'(cpu_reset_req), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_checksum", checksum, 32'd0);
  endtask

  // Memory slave: at each negedge record accepted requests and check that a
  // stalled write is held stable; just after each posedge drive waitrequest
  // (none / 3-cycle stall per request / random) and return read data.
  initial begin : slave_model
    logic              held;
    logic [31:0]       held_data;
    logic [ADDR_W-1:0] held_addr;
    logic [3:0]        held_be;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_addr;
    int                stall_cnt;
    held = 1'b0; held_data = '0; held_addr = '0; held_be = '0;
    rd_pend = 1'b0; rd_addr = '0; stall_cnt = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdata      = 32'd0;
    bus.avm_readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held    = 1'b0;
        rd_pend = 1'b0;
      end
      if (bus.avm_write) begin
        if (held) begin
          checkOutput("hold_data", bus.avm_writedata, held_data);
          checkOutput("hold_addr", 32'(bus.avm_address), 32'(held_addr));
          checkOutput("hold_be", 32'(bus.avm_byteenable), 32'(held_be));
        end
        if (!bus.avm_waitrequest) begin
          wr_addr_q.push_back(bus.avm_address);
          wr_data_q.push_back(bus.avm_writedata);
          wr_be_q.push_back(bus.avm_byteenable);
          for (int k = 0; k < 4; k++)
            if (bus.avm_byteenable[k]) mem[bus.avm_address][8*k +: 8] = bus.avm_writedata[8*k +: 8];
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_data = bus.avm_writedata;
          held_addr = bus.avm_address;
          held_be   = bus.avm_byteenable;
        end
      end else begin
        held = 1'b0;
      end
      if (bus.avm_read) begin
        read_seen++;
        if (!bus.avm_waitrequest) begin
          rd_pend = 1'b1;
          rd_addr = bus.avm_address;
        end
      end
      @(posedge clk);
      #1;
      if (rd_pend) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = mem[rd_addr] ^ ((corrupt_en && (rd_addr == corrupt_addr)) ? 32'h1 : 32'h0);
        rd_pend = 1'b0;
      end else begin
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = $urandom;
      end
      if (stall_mode == 1 && (bus.avm_write || bus.avm_read)) begin
        if (stall_cnt < 3) begin
          bus.avm_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          bus.avm_waitrequest = 1'b0;
          stall_cnt = 0;
        end
      end else if (stall_mode == 2) begin
        bus.avm_waitrequest = ($urandom_range(0, 2) == 0);
      end else begin
        bus.avm_waitrequest = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  // Runs one load. pat < 0 gives random bytes, otherwise bytes pat, pat+1, ...
  // abort_after >= 0 returns (unchecked) once that many bytes were accepted.
  task automatic applyStimulus(input int base, input int len, input int smode, input bit gaps,
                               input bit corrupt, input int abort_after, input int pat);
    logic [7:0]  bytes [$];
    logic [31:0] exp_data [$];
    logic [3:0]  exp_be [$];
    logic [31:0] exp_sum;
    logic [31:0] word;
    logic [3:0]  be;
    bit          exp_err;
    bit          range_bad;
    int          nwords;
    int          idx;
    int          cycles;
    int          nchk;

    for (int i = 0; i < len; i++) bytes.push_back((pat < 0) ? 8'($urandom) : 8'(pat + i));
    nwords    = (len + 3) / 4;
    range_bad = (len != 0) && (nwords > DEPTH - base);
    exp_err   = range_bad;
    exp_sum   = 32'd0;
    if (len != 0 && !range_bad) begin
      for (int wi = 0; wi < nwords; wi++) begin
        word = 32'd0;
        be   = 4'd0;
        for (int k = 0; k < 4; k++) begin
          if (4*wi + k < len) begin
            word[8*k +: 8] = bytes[4*wi + k];
            be[k] = 1'b1;
          end
        end
        exp_data.push_back(word);
        exp_be.push_back(be);
        exp_sum = exp_sum + word;
      end
    end
`ifdef LMS_CTR_OC_MEM_LOADER_VERIFY_EN
    if (corrupt && !range_bad && nwords >= 2) exp_err = 1'b1;
`endif

    corrupt_en   = corrupt;
    corrupt_addr = ADDR_W'(base + 1);
    stall_mode   = smode;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_be_q.delete();
    read_seen = 0;

    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    len_bytes = LEN_W'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_rise", 32'(busy), 32'd1);
    checkOutput("cpu_reset_req_rise", 32'(cpu_reset_req), 32'd1);

    idx    = 0;
    cycles = 0;
    while (!done && cycles < 4000) begin
      if (abort_after >= 0 && idx >= abort_after) begin
        bus.st_valid = 1'b0;
        return;
      end
      bus.st_valid = (idx < len) && (!gaps || $urandom_range(0, 3) != 0);
      bus.st_data  = (idx < len) ? bytes[idx] : 8'h00;
      @(negedge clk);
      if (bus.st_valid && bus.st_ready) idx++;
      @(posedge clk);
      #1;
      cycles++;
    end
    bus.st_valid = 1'b0;

    checkOutput("done_seen", 32'(done), 32'd1);
    checkOutput("busy_fall", 32'(busy), 32'd0);
    checkOutput("checksum", checksum, exp_sum);
    checkOutput("error", 32'(error), 32'(exp_err));
    checkOutput("write_count", 32'(wr_addr_q.size()), 32'(exp_data.size()));
    nchk = (wr_addr_q.size() < exp_data.size()) ? wr_addr_q.size() : exp_data.size();
    for (int i = 0; i < nchk; i++) begin
      checkOutput("write_addr", 32'(wr_addr_q[i]), 32'(base + i));
      checkOutput("write_data", wr_data_q[i], exp_data[i]);
      checkOutput("write_be", 32'(wr_be_q[i]), 32'(exp_be[i]));
    end
`ifndef LMS_CTR_OC_MEM_LOADER_VERIFY_EN
    checkOutput("no_read", 32'(read_seen), 32'd0);
`endif
    if (len == 0 || range_bad) checkOutput("done_latency", 32'(cycles), 32'd1);

    // Offer a start during the done cycle; it must be ignored.
    start     = 1'b1;
    base_addr = '0;
    len_bytes = LEN_W'(4);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("done_pulse_width", 32'(done), 32'd0);
    checkOutput("start_on_done_ignored", 32'(busy), 32'd0);
    checkOutput("error_sticky", 32'(error), 32'(exp_err));
  endtask

  initial begin : main
    int base;
    int len;
    bus.st_valid = 1'b0;
    bus.st_data  = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    checkResetValues();
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] directed loads");
    applyStimulus(0, 8, 0, 1'b0, 1'b0, -1, 8'h01);
    applyStimulus(10, 6, 1, 1'b0, 1'b0, -1, 8'hAA);
    applyStimulus(4090, 28, 0, 1'b0, 1'b0, -1, -1);
    applyStimulus(0, 0, 0, 1'b0, 1'b0, -1, -1);
    applyStimulus(4088, 32, 2, 1'b1, 1'b0, -1, -1);
`ifdef LMS_CTR_OC_MEM_LOADER_VERIFY_EN
    applyStimulus(100, 12, 0, 1'b0, 1'b1, -1, -1);
    applyStimulus(200, 7, 2, 1'b0, 1'b0, -1, -1);
`endif

    $display("[TB] reset in the middle of a load");
    applyStimulus(0, 8, 0, 1'b0, 1'b0, 3, 8'h01);
    #2;
    reset_n = 1'b0;
    #1;
    checkResetValues();
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(0, 8, 0, 1'b0, 1'b0, -1, 8'h11);

    $display("[TB] randomized loads");
    for (int r = 0; r < 12; r++) begin
      base = ($urandom_range(0, 3) == 0) ? $urandom_range(4060, 4095) : $urandom_range(0, 4000);
      len  = $urandom_range(0, 40);
`ifdef LMS_CTR_OC_MEM_LOADER_VERIFY_EN
      applyStimulus(base, len, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1, -1);
`else
      applyStimulus(base, len, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0, -1, -1);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
